adat_signal_supervisor: RTL and testbench
=========================================

// Module: adat_signal_supervisor
// PURPOSE
//  Supervises the zero-held ADAT input line and sequences the receive path.
//  Detects edges, times gaps, counts edges per window and runs a lock FSM.
//  Enables the downstream ADAT decoder only on a stable signal, and mutes audio on loss.
//  Sits between the zero sample-and-hold stage and the ADAT frame decoder.
// PARAMETERS
//  WINDOW        256  measurement window length in clk_i cycles (>=2)
//  MIN_EDGES     64   edges required in a window for it to count as good (1..WINDOW)
//  EDGE_TIMEOUT  32   consecutive edgeless cycles that count as signal loss (>=2)
//  LOCK_WINDOWS  4    consecutive good windows required to lock (>=1)
//  HOLDOFF       1024 cycles spent in HOLDOFF after a loss, before re-acquiring (>=1)
// PORTS
//  clk_i         in   1  system clock
//  rst_i         in   1  asynchronous, active-high reset
//  signal_i      in   1  zero-held ADAT line, already synchronous to clk_i
//  decoder_en_o  out  1  enable for the ADAT decoder; high only in LOCKED
//  mute_o        out  1  audio mute; high in every state except LOCKED
//  locked_o      out  1  high in LOCKED
//  lost_o        out  1  one-cycle pulse on the LOCKED->HOLDOFF transition
//  state_o       out  2  IDLE=0, ACQUIRE=1, LOCKED=2, HOLDOFF=3
// BEHAVIOUR
//  Reset and registers
//  - Async reset: state=IDLE, all counters=0, signal_d=0.
//  - Output reset values: decoder_en_o=0, locked_o=0, lost_o=0, mute_o=1, state_o=0.
//  - All outputs are registered and decoded from the state register.
//  Edge and gap detection
//  - edge = signal_i ^ signal_d, where signal_d is signal_i delayed by one register.
//  - gap_cnt: cleared on an edge cycle, otherwise +1, saturating at EDGE_TIMEOUT.
//  - timeout = (gap_cnt == EDGE_TIMEOUT), i.e. after EDGE_TIMEOUT consecutive edgeless cycles.
//  Windows
//  - win_cnt runs 0..WINDOW-1 and wraps; window end is the cycle where win_cnt == WINDOW-1.
//  - edge_cnt counts edges in the window, including one on the end cycle, saturating at WINDOW.
//  - good = edge_cnt_incl >= MIN_EDGES.
//  - win_cnt and edge_cnt clear at window end and on every state change.
//  FSM (each transition takes effect on the next clk_i edge)
//  - IDLE: counters held clear; the first edge moves to ACQUIRE with good_cnt=0.
//  - ACQUIRE:
//      timeout -> IDLE.
//      window end and !good -> IDLE.
//      window end and good -> good_cnt+1; when it reaches LOCK_WINDOWS -> LOCKED.
//  - LOCKED: timeout, or window end and !good -> HOLDOFF; lost_o pulses that cycle.
//  - HOLDOFF: edges ignored; after HOLDOFF cycles -> IDLE; gap_cnt, edge_cnt and good_cnt cleared.
//  Latency
//  - mute_o and decoder_en_o change in the same cycle as state_o; no extra latency.
//  Simultaneous events
//  - An edge in the same cycle as gap_cnt would reach EDGE_TIMEOUT: the edge wins, no timeout.
//  - Timeout on a window-end cycle: timeout wins and the window is treated as bad.
//  - Reset mid-operation: outputs return to their reset values immediately, without waiting
//    for a clock edge.
//  Counter widths
//  - Each counter is $clog2(limit+1) bits.
//  - All compares are unsigned; no counter wraps except win_cnt.
// TESTING (WINDOW=16 MIN_EDGES=4 EDGE_TIMEOUT=8 LOCK_WINDOWS=2 HOLDOFF=10)
//  1 Toggle signal_i every 2 cycles from IDLE -> ACQUIRE, then LOCKED after 2 windows
//    (~33 cycles); locked_o=1, mute_o=0.
//  2 In LOCKED, hold signal_i constant -> on the 8th edgeless cycle lost_o pulses once,
//    state=3, mute_o=1; after 10 cycles state=0.
//  3 Toggle every 5 cycles in ACQUIRE (3 edges/window) -> IDLE at window end; locked_o stays 0.
//  4 Edges every 8 cycles -> no timeout; stretch one gap to 9 cycles -> timeout fires
//    exactly on the 8th edgeless cycle.
//  5 Toggle continuously during HOLDOFF -> state stays 3 for 10 cycles, then IDLE,
//    then ACQUIRE on the next edge.
//  6 Assert rst_i asynchronously while LOCKED -> locked_o=0, mute_o=1, decoder_en_o=0,
//    state_o=0 before the next clk_i edge.

Source files
------------

// File: rtl/adat_signal_supervisor.sv
// ADAT input supervisor: edge/gap timing, per-window edge counts and a
// lock FSM that gates the frame decoder and mutes audio on signal loss.
module adat_signal_supervisor #(
  parameter int WINDOW       = 256,
  parameter int MIN_EDGES    = 64,
  parameter int EDGE_TIMEOUT = 32,
  parameter int LOCK_WINDOWS = 4,
  parameter int HOLDOFF      = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       signal_i,
  output logic       decoder_en_o,
  output logic       mute_o,
  output logic       locked_o,
  output logic       lost_o,
  output logic [1:0] state_o
);

  localparam int GW = $clog2(EDGE_TIMEOUT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(WINDOW + 1);
  localparam int CW = $clog2(LOCK_WINDOWS + 1);
  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          signal_d;
  logic [GW-1:0] gap_q, gap_d, gap_inc, gap_nxt;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] ecnt_q, ecnt_d, ecnt_incl;
  logic [CW-1:0] good_q, good_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          lost_q, lost_d;
  logic          edge_w, timeout, win_end, good;

  assign edge_w  = signal_i ^ signal_d;
  assign gap_inc = (gap_q == GW'(EDGE_TIMEOUT)) ? gap_q
                                                : gap_q + 1'b1;
  assign gap_nxt = edge_w ? '0 : gap_inc;
  // An edge on the would-be timeout cycle clears the gap, so it wins.
  assign timeout = (gap_nxt == GW'(EDGE_TIMEOUT));
  assign win_end = (win_q == WW'(WINDOW - 1));
  assign ecnt_incl = (edge_w && ecnt_q != EW'(WINDOW)) ? ecnt_q + 1'b1
                                                       : ecnt_q;
  assign good = (ecnt_incl >= EW'(MIN_EDGES));

  // Next-state, counter updates and loss pulse request.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_nxt;
    win_d   = win_end ? '0 : win_q + 1'b1;
    ecnt_d  = win_end ? '0 : ecnt_incl;
    good_d  = good_q;
    hold_d  = '0;
    lost_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        gap_d  = '0;
        win_d  = '0;
        ecnt_d = '0;
        good_d = '0;
        if (edge_w) state_d = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (timeout) begin
          state_d = S_IDLE;
        end else if (win_end) begin
          if (!good)
            state_d = S_IDLE;
          else if (good_q + 1'b1 == CW'(LOCK_WINDOWS))
            state_d = S_LOCKED;
          else
            good_d = good_q + 1'b1;
        end
      end
      S_LOCKED: begin
        if (timeout || (win_end && !good)) begin
          state_d = S_HOLDOFF;
          lost_d  = 1'b1;
        end
      end
      S_HOLDOFF: begin
        gap_d  = '0;
        win_d  = '0;
        ecnt_d = '0;
        good_d = '0;
        if (hold_q == HW'(HOLDOFF - 1))
          state_d = S_IDLE;
        else
          hold_d = hold_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      win_d  = '0;
      ecnt_d = '0;
      good_d = '0;
    end
  end

  // State, counters, input delay and loss pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      signal_d <= 1'b0;
      gap_q    <= '0;
      win_q    <= '0;
      ecnt_q   <= '0;
      good_q   <= '0;
      hold_q   <= '0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      signal_d <= signal_i;
      gap_q    <= gap_d;
      win_q    <= win_d;
      ecnt_q   <= ecnt_d;
      good_q   <= good_d;
      hold_q   <= hold_d;
      lost_q   <= lost_d;
    end
  end

  assign state_o      = state_q;
  assign locked_o     = (state_q == S_LOCKED);
  assign decoder_en_o = (state_q == S_LOCKED);
  assign mute_o       = (state_q != S_LOCKED);
  assign lost_o       = lost_q;

endmodule

// File: tb/tb_adat_signal_supervisor.sv
// Bench for adat_signal_supervisor: vector table plus hand sequences,
// expectations queued with stimulus and compared after each clock.
module tb_adat_signal_supervisor;

  logic       clk;
  logic       rst;
  logic       signal_i;
  logic       decoder_en_o;
  logic       mute_o;
  logic       locked_o;
  logic       lost_o;
  logic [1:0] state_o;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string      nm;
    logic [1:0] st;
    logic       lo;
  } exp_t;

  typedef struct {
    string      nm;
    int         p;
    int         n;
    logic [1:0] st;
    logic       lo;
  } vec_t;

  exp_t q[$];
  vec_t vt[12];
  logic lvl;
  int   since;

  adat_signal_supervisor #(
    .WINDOW(16), .MIN_EDGES(4), .EDGE_TIMEOUT(8),
    .LOCK_WINDOWS(2), .HOLDOFF(10)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .signal_i(signal_i),
    .decoder_en_o(decoder_en_o),
    .mute_o(mute_o),
    .locked_o(locked_o),
    .lost_o(lost_o),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_pop();
    exp_t e;
    logic [4:0] act, req;
    logic lk;
    while (q.size() > 0) begin
      e   = q.pop_front();
      lk  = (e.st == 2'd2);
      act = {state_o, locked_o, decoder_en_o, mute_o, lost_o};
      req = {e.st, lk, lk, ~lk, e.lo};
      total++;
      if (act !== req)
        $display("FAIL %s: {st,lk,en,mu,lo} got %b want %b",
                 e.nm, act, req);
      else
        passed++;
    end
  endtask

  task automatic cyc(input logic s, input logic [1:0] st,
                     input logic lo, input string nm);
    signal_i = s;
    q.push_back('{nm, st, lo});
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic tg(input logic [1:0] st, input logic lo,
                    input string nm);
    lvl = ~lvl;
    cyc(lvl, st, lo, nm);
  endtask

  task automatic hd(input logic [1:0] st, input logic lo,
                    input string nm);
    cyc(lvl, st, lo, nm);
  endtask

  initial begin
    vt[0]  = '{"acq_enter",  2,  1, 2'd1, 1'b0};
    vt[1]  = '{"acq_win1",   2, 16, 2'd1, 1'b0};
    vt[2]  = '{"acq_win2",   2, 15, 2'd1, 1'b0};
    vt[3]  = '{"lock",       2,  1, 2'd2, 1'b0};
    vt[4]  = '{"lock_gap",   0,  7, 2'd2, 1'b0};
    vt[5]  = '{"lost",       0,  1, 2'd3, 1'b1};
    vt[6]  = '{"lost_once",  0,  1, 2'd3, 1'b0};
    vt[7]  = '{"holdoff",    0,  8, 2'd3, 1'b0};
    vt[8]  = '{"hold_exit",  0,  1, 2'd0, 1'b0};
    vt[9]  = '{"slow_enter", 5,  1, 2'd1, 1'b0};
    vt[10] = '{"slow_win",   5, 15, 2'd1, 1'b0};
    vt[11] = '{"slow_bad",   5,  1, 2'd0, 1'b0};

    rst      = 1'b1;
    signal_i = 1'b0;
    lvl      = 1'b0;
    since    = 100;
    #2;
    q.push_back('{"reset", 2'd0, 1'b0});
    check_pop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < vt[v].n; i++) begin
        if (vt[v].p != 0 && since >= vt[v].p - 1) begin
          lvl   = ~lvl;
          since = 0;
        end else begin
          since++;
        end
        cyc(lvl, vt[v].st, vt[v].lo, vt[v].nm);
      end
    end

    // 7-cycle gap survives; 8 edgeless cycles time out exactly.
    tg(2'd1, 1'b0, "t4_enter");
    repeat (3) tg(2'd1, 1'b0, "t4_burst");
    repeat (7) hd(2'd1, 1'b0, "t4_gap7");
    tg(2'd1, 1'b0, "t4_edge_wins");
    repeat (7) hd(2'd1, 1'b0, "t4_gap_win_good");
    hd(2'd0, 1'b0, "t4_timeout8");

    // Lock, lose, then toggle through the whole holdoff.
    tg(2'd1, 1'b0, "t5_enter");
    repeat (31) tg(2'd1, 1'b0, "t5_acq");
    tg(2'd2, 1'b0, "t5_lock");
    repeat (7) hd(2'd2, 1'b0, "t5_gap");
    hd(2'd3, 1'b1, "t5_lost");
    repeat (9) tg(2'd3, 1'b0, "t5_hold_ignore");
    tg(2'd0, 1'b0, "t5_idle");
    tg(2'd1, 1'b0, "t5_reacq");

    // Asynchronous reset while locked.
    repeat (31) tg(2'd1, 1'b0, "t6_acq");
    tg(2'd2, 1'b0, "t6_lock");
    #3;
    rst = 1'b1;
    #1;
    q.push_back('{"t6_async_rst", 2'd0, 1'b0});
    check_pop();
    lvl      = 1'b0;
    signal_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 2'd0, 1'b0, "t6_after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
